timer_bank: RTL and testbench

//   Multi-channel programmable interval timer; parametrised successor of the single fixed-period timer.

---
 rtl/timer_bank.sv | 121 ++++++++++++
 tb/tb_timer_bank.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer with a shared prescaler.
// Each channel has its own reload value, periodic/one-shot mode and a sticky pending flag.
module timer_bank #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 1,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0]  period,
  input  logic              mode,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] irq,
  output logic [NUM_CH-1:0] running
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  localparam logic MODE_ONESHOT = 1'b1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick;

  logic [NUM_CH-1:0] state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  reload_q [NUM_CH];
  logic [CNT_W-1:0]  reload_d [NUM_CH];

  logic [NUM_CH-1:0] wr_hit;
  logic              cfg_start;

  assign tick    = (pre_q == PRE_W'(PRESCALE - 1));
  assign pre_d   = tick ? '0 : pre_q + PRE_W'(1);
  assign irq     = pend_q;
  assign running = state_q;

  // Out-of-range selects match no channel and are dropped.
  assign cfg_start = enable && (period != '0);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = we && (ch_sel == SEL_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      pend_d[i]   = pend_q[i];
      mode_d[i]   = mode_q[i];
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];

      if (ack[i]) begin
        pend_d[i] = 1'b0;
      end

      // Expiry is applied after ack so a simultaneous set keeps the flag high.
      if (state_q[i] == ST_COUNT && tick) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          pend_d[i] = 1'b1;
          if (mode_q[i] == MODE_ONESHOT) begin
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i] = reload_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      // A config write overrides both expiry and ack on its channel.
      if (wr_hit[i]) begin
        pend_d[i] = 1'b0;
        if (cfg_start) begin
          reload_d[i] = period;
          cnt_d[i]    = period;
          mode_d[i]   = mode;
          state_d[i]  = ST_COUNT;
        end else begin
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      state_q <= {NUM_CH{ST_IDLE}};
      pend_q  <= '0;
      mode_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized traffic
// compared against an event-time reference model.
module tb_timer_bank;

  localparam int unsigned NCH = 6;
  localparam int unsigned CW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, we, mode, enable;
  logic [2:0]     ch_sel;
  logic [CW-1:0]  period;
  logic [NCH-1:0] ack, irq, running;

  logic           rst4, we4, mode4, en4;
  logic [2:0]     sel4;
  logic [15:0]    per4;
  logic [7:0]     ack4, irq4, run4;

  timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .ch_sel  (ch_sel),
    .period  (period),
    .mode    (mode),
    .enable  (enable),
    .ack     (ack),
    .irq     (irq),
    .running (running)
  );

  timer_bank #(.NUM_CH(8), .CNT_W(16), .PRESCALE(4)) dut4 (
    .clk     (clk),
    .reset   (rst4),
    .we      (we4),
    .ch_sel  (sel4),
    .period  (per4),
    .mode    (mode4),
    .enable  (en4),
    .ack     (ack4),
    .irq     (irq4),
    .running (run4)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: each running channel knows the absolute edge of its next expiry.
  bit m_run  [NCH];
  bit m_pend [NCH];
  bit m_one  [NCH];
  int m_per  [NCH];
  int m_next [NCH];

  function automatic logic [NCH-1:0] m_irq();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_pend[c];
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_running();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_run[c];
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_one[c] = 0; m_per[c] = 0; m_next[c] = 0;
    end
  endtask

  task automatic model_edge(input bit w, input int sel, input int per, input bit md,
                            input bit en, input logic [NCH-1:0] ak);
    bit fire;
    for (int c = 0; c < NCH; c++) begin
      fire = m_run[c] && (edge_n == m_next[c]);
      if (w && sel == c) begin
        m_pend[c] = 0;
        if (en && per != 0) begin
          m_run[c] = 1; m_per[c] = per; m_one[c] = md; m_next[c] = edge_n + per;
        end else begin
          m_run[c] = 0;
        end
      end else if (fire) begin
        m_pend[c] = 1;
        if (m_one[c]) m_run[c] = 0;
        else m_next[c] = edge_n + m_per[c];
      end else if (ak[c]) begin
        m_pend[c] = 0;
      end
    end
  endtask

  task automatic cyc(input bit w, input int sel, input int per, input bit md, input bit en,
                     input logic [NCH-1:0] ak);
    we = w; ch_sel = sel[2:0]; period = per[CW-1:0]; mode = md; enable = en; ack = ak;
    @(posedge clk);
    edge_n++;
    model_edge(w, sel, per, md, en, ak);
    #1;
    we = 1'b0; ack = '0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    model_clear();
    #10;
    checks++;
    if (irq !== '0 || running !== '0) begin
      errors++; $display("FAIL reset_hold irq=%b running=%b expected 0/0", irq, running);
    end
    checks++;
    if (irq4 !== '0 || run4 !== '0) begin
      errors++; $display("FAIL reset_hold4 irq=%b running=%b expected 0/0", irq4, run4);
    end
    reset = 1'b0;
    for (int t = 0; t < 20; t++) begin
      idle();
      checks++;
      if (irq !== '0 || running !== '0) begin
        errors++; $display("FAIL reset_idle t=%0d irq=%b running=%b expected 0/0", t, irq, running);
      end
    end
  endtask

  task automatic test_periodic();
    logic [NCH-1:0] a;
    cyc(1, 0, 7, 0, 1, '0);
    for (int t = 1; t <= 14; t++) begin
      a = '0; a[0] = (t == 8);
      cyc(0, 0, 0, 0, 0, a);
      checks++;
      if (irq[0] !== (t == 7 || t == 14) || running[0] !== 1'b1) begin
        errors++;
        $display("FAIL periodic t=%0d irq0=%b running0=%b expected %b/1",
                 t, irq[0], running[0], (t == 7 || t == 14));
      end
    end
    cyc(1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_oneshot();
    logic [NCH-1:0] a;
    cyc(1, 3, 4, 1, 1, '0);
    for (int t = 1; t <= 4; t++) begin
      idle();
      checks++;
      if (irq[3] !== (t == 4) || running[3] !== (t < 4)) begin
        errors++;
        $display("FAIL oneshot t=%0d irq3=%b running3=%b expected %b/%b",
                 t, irq[3], running[3], (t == 4), (t < 4));
      end
    end
    a = '0; a[3] = 1'b1;
    cyc(0, 0, 0, 0, 0, a);
    for (int t = 0; t < 50; t++) begin
      idle();
      checks++;
      if (irq[3] !== 1'b0 || running[3] !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_after t=%0d irq3=%b running3=%b expected 0/0", t, irq[3], running[3]);
      end
    end
  endtask

  task automatic test_set_beats_ack();
    logic [NCH-1:0] a;
    cyc(1, 1, 1, 0, 1, '0);
    a = '0; a[1] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      cyc(0, 0, 0, 0, 0, a);
      checks++;
      if (irq[1] !== 1'b1) begin
        errors++; $display("FAIL set_beats_ack t=%0d irq1=%b expected 1", t, irq[1]);
      end
    end
    cyc(1, 1, 0, 0, 0, a);
    checks++;
    if (irq[1] !== 1'b0 || running[1] !== 1'b0) begin
      errors++; $display("FAIL set_beats_ack_stop irq1=%b running1=%b expected 0/0", irq[1], running[1]);
    end
  endtask

  task automatic test_stop_restart();
    cyc(1, 2, 10, 0, 1, '0);
    repeat (4) idle();
    cyc(1, 2, 10, 0, 0, '0);
    for (int t = 0; t < 15; t++) begin
      idle();
      checks++;
      if (irq[2] !== 1'b0 || running[2] !== 1'b0) begin
        errors++; $display("FAIL stopped t=%0d irq2=%b running2=%b expected 0/0", t, irq[2], running[2]);
      end
    end
    cyc(1, 2, 3, 0, 1, '0);
    for (int t = 1; t <= 3; t++) begin
      idle();
      checks++;
      if (irq[2] !== (t == 3)) begin
        errors++; $display("FAIL restart t=%0d irq2=%b expected %b", t, irq[2], (t == 3));
      end
    end
    cyc(1, 2, 0, 0, 1, '0);
    checks++;
    if (running[2] !== 1'b0 || irq[2] !== 1'b0) begin
      errors++; $display("FAIL period_zero running2=%b irq2=%b expected 0/0", running[2], irq[2]);
    end
  endtask

  task automatic test_max_period();
    cyc(1, 4, 255, 0, 1, '0);
    for (int t = 1; t <= 255; t++) begin
      idle();
      if (t >= 254) begin
        checks++;
        if (irq[4] !== (t == 255) || running[4] !== 1'b1) begin
          errors++;
          $display("FAIL max_period t=%0d irq4=%b running4=%b expected %b/1",
                   t, irq[4], running[4], (t == 255));
        end
      end
    end
    cyc(1, 4, 0, 0, 0, '0);
  endtask

  task automatic test_write_beats_expiry();
    cyc(1, 5, 3, 0, 1, '0);
    repeat (2) idle();
    cyc(1, 5, 5, 0, 1, '0);
    checks++;
    if (irq[5] !== 1'b0 || running[5] !== 1'b1) begin
      errors++; $display("FAIL write_beats_expiry irq5=%b running5=%b expected 0/1", irq[5], running[5]);
    end
    repeat (4) idle();
    checks++;
    if (irq[5] !== 1'b0) begin
      errors++; $display("FAIL reload_early irq5=%b expected 0", irq[5]);
    end
    idle();
    checks++;
    if (irq[5] !== 1'b1) begin
      errors++; $display("FAIL reload_fire irq5=%b expected 1", irq[5]);
    end
    cyc(1, 5, 0, 0, 0, '0);
  endtask

  task automatic test_ignored_write();
    cyc(1, 6, 5, 0, 1, '0);
    cyc(1, 7, 5, 0, 1, '0);
    repeat (8) idle();
    checks++;
    if (running !== '0 || irq !== '0) begin
      errors++; $display("FAIL ignored_write running=%b irq=%b expected 0/0", running, irq);
    end
  endtask

  task automatic test_random();
    bit w, md, en;
    int sel, per, r;
    logic [NCH-1:0] a;
    for (int n = 0; n < 500; n++) begin
      w   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      r   = $urandom_range(0, 9);
      per = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 12);
      md  = $urandom_range(0, 1);
      en  = ($urandom_range(0, 4) != 0);
      a   = ($urandom_range(0, 2) == 0) ? NCH'($urandom_range(0, 63)) : '0;
      cyc(w, sel, per, md, en, a);
      checks++;
      if (irq !== m_irq() || running !== m_running()) begin
        errors++;
        $display("FAIL random n=%0d irq=%b running=%b expected %b/%b",
                 n, irq, running, m_irq(), m_running());
      end
    end
  endtask

  task automatic test_prescale();
    int e4, k, first, expn;
    rst4 = 1'b0;
    e4 = 0;
    repeat (1 + $urandom_range(0, 3)) begin
      idle(); e4++;
    end
    we4 = 1'b1; sel4 = 3'd0; per4 = 16'd2; mode4 = 1'b0; en4 = 1'b1;
    idle(); e4++;
    we4 = 1'b0;
    k = e4;
    checks++;
    if (run4[0] !== 1'b1) begin
      errors++; $display("FAIL prescale_start running0=%b expected 1", run4[0]);
    end
    // Ticks land on every fourth edge after reset release; two ticks are needed.
    expn = (k / 4 + 2) * 4;
    first = -1;
    for (int n = 0; n < 12; n++) begin
      idle(); e4++;
      if (first < 0 && irq4[0] === 1'b1) first = e4;
    end
    checks++;
    if (first != expn || (first - k) < 5 || (first - k) > 8) begin
      errors++; $display("FAIL prescale_fire edge=%0d expected %0d (write at %0d)", first, expn, k);
    end
    #3;
    rst4 = 1'b1;
    #1;
    checks++;
    if (irq4 !== '0 || run4 !== '0) begin
      errors++; $display("FAIL async_reset irq=%b running=%b expected 0/0", irq4, run4);
    end
    idle();
    rst4 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      idle();
      checks++;
      if (irq4 !== '0 || run4 !== '0) begin
        errors++; $display("FAIL post_reset t=%0d irq=%b running=%b expected 0/0", t, irq4, run4);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rst4 = 1'b1;
    we = 1'b0; ch_sel = '0; period = '0; mode = 1'b0; enable = 1'b0; ack = '0;
    we4 = 1'b0; sel4 = '0; per4 = '0; mode4 = 1'b0; en4 = 1'b0; ack4 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_set_beats_ack();
    test_stop_restart();
    test_max_period();
    test_write_beats_expiry();
    test_ignored_write();
    test_random();
    test_prescale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
